// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared clock constants and sizing helpers for board_io_conditioner
package board_io_pkg;

  localparam int CLK_HZ_ICEBREAKER = 12000000;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button bit: 2-flop synchroniser, stability counter, level and strobes
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_q,
  output logic btn_press,
  output logic btn_release
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic [DW-1:0] dc_q, dc_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  assign s = sync_q[1];

  // Any sample equal to the accepted level restarts the stability count.
  always_comb begin
    dc_d    = dc_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s == level_q) begin
      dc_d = '0;
    end else if (dc_q == DC_LAST) begin
      dc_d    = '0;
      level_d = s;
      press_d = s;
      rel_d   = ~s;
    end else begin
      dc_d = dc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      dc_q    <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_in};
      dc_q    <= dc_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_q       = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

endmodule

// File: rtl/board_io_conditioner.sv
// rtl/board_io_conditioner.sv - board pin conditioning: core reset sync, button debounce,
// heartbeat and active-low LED pulse stretching
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int N_BTN            = 3,
  parameter int N_LED            = 8,
  parameter int DEBOUNCE_CYCLES  = ms_to_cycles(CLK_HZ_ICEBREAKER, 10),
  parameter int HEARTBEAT_CYCLES = ms_to_cycles(CLK_HZ_ICEBREAKER, 1000),
  parameter int STRETCH_CYCLES   = ms_to_cycles(CLK_HZ_ICEBREAKER, 100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_LED-1:0] led_in,
  output logic             rst_out_n,
  output logic [N_BTN-1:0] btn_q,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             heartbeat,
  output logic [N_LED-1:0] led_out_n
);

  localparam int HW = cnt_w(HEARTBEAT_CYCLES - 1);
  localparam logic [HW-1:0] HC_LAST = HW'(HEARTBEAT_CYCLES - 1);
  // A zero stretch still needs a one-bit counter to stay legal.
  localparam int SW = (cnt_w(STRETCH_CYCLES) < 1) ? 1 : cnt_w(STRETCH_CYCLES);
  localparam logic [SW-1:0] SC_LOAD = SW'(STRETCH_CYCLES);

  logic [1:0]    rst_sync_q;
  logic [HW-1:0] hc_q, hc_d;
  logic          hb_q, hb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_out_n = rst_sync_q[1];

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in     (btn_in[b]),
      .btn_q      (btn_q[b]),
      .btn_press  (btn_press[b]),
      .btn_release(btn_release[b])
    );
  end

  always_comb begin
    hc_d = hc_q + 1'b1;
    hb_d = hb_q;
    if (hc_q == HC_LAST) begin
      hc_d = '0;
      hb_d = ~hb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      hb_q <= 1'b0;
    end else begin
      hc_q <= hc_d;
      hb_q <= hb_d;
    end
  end

  assign heartbeat = hb_q;

  for (genvar i = 0; i < N_LED; i++) begin : g_led
    logic [SW-1:0] sc_q, sc_d;
    logic          led_n_q, led_n_d;

    // A fresh request reloads rather than accumulates the stretch.
    always_comb begin
      sc_d    = sc_q;
      led_n_d = 1'b1;
      if (led_in[i]) begin
        sc_d    = SC_LOAD;
        led_n_d = 1'b0;
      end else if (sc_q != '0) begin
        sc_d    = sc_q - 1'b1;
        led_n_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sc_q    <= '0;
        led_n_q <= 1'b1;
      end else begin
        sc_q    <= sc_d;
        led_n_q <= led_n_d;
      end
    end

    assign led_out_n[i] = led_n_q;
  end

endmodule

// File: tb/tb_board_io_conditioner.sv
// tb/tb_board_io_conditioner.sv - scoreboard bench for board_io_conditioner
module tb_board_io_conditioner;

  localparam int N_BTN = 2;
  localparam int N_LED = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] btn_in = '0;
  logic [N_LED-1:0] led_in = '0;
  logic             rst_out_n;
  logic [N_BTN-1:0] btn_q, btn_press, btn_release;
  logic             heartbeat;
  logic [N_LED-1:0] led_out_n;

  board_io_conditioner #(
    .N_BTN(N_BTN), .N_LED(N_LED), .DEBOUNCE_CYCLES(4),
    .HEARTBEAT_CYCLES(5), .STRETCH_CYCLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .led_in(led_in),
    .rst_out_n(rst_out_n), .btn_q(btn_q), .btn_press(btn_press),
    .btn_release(btn_release), .heartbeat(heartbeat), .led_out_n(led_out_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int c; logic [1:0] press; logic [1:0] rel; logic [1:0] q;} btn_ev_t;
  typedef struct {int c; logic [1:0] val;} lvl_ev_t;

  btn_ev_t btn_exp[$];
  lvl_ev_t hb_exp[$];
  lvl_ev_t led_exp[$];
  bit      hb_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_btn(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] q);
    btn_ev_t e;
    e.c = c; e.press = p; e.rel = r; e.q = q;
    btn_exp.push_back(e);
  endtask

  task automatic push_led(input int c, input logic [1:0] v);
    lvl_ev_t e;
    e.c = c; e.val = v;
    led_exp.push_back(e);
  endtask

  task automatic push_hb(input int c, input logic v);
    lvl_ev_t e;
    e.c = c; e.val = {1'b0, v};
    hb_exp.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every observed output event consumes the oldest expectation.
  logic [1:0] prev_q, prev_led;
  logic       prev_hb;
  btn_ev_t    be;
  lvl_ev_t    le;

  always @(negedge clk) begin
    if (rst_n) begin
      if ((btn_press | btn_release) != 2'b00) begin
        if (btn_exp.size() == 0) begin
          check("btn_unexpected_strobe", {28'd0, btn_press, btn_release}, 32'd0);
        end else begin
          be = btn_exp.pop_front();
          check("btn_cycle", cyc, be.c);
          check("btn_press", {30'd0, btn_press}, {30'd0, be.press});
          check("btn_release", {30'd0, btn_release}, {30'd0, be.rel});
          check("btn_q", {30'd0, btn_q}, {30'd0, be.q});
        end
      end else if (btn_q !== prev_q) begin
        check("btn_q_without_strobe", {30'd0, btn_q}, {30'd0, prev_q});
      end
      if (hb_en && heartbeat !== prev_hb) begin
        if (hb_exp.size() == 0) begin
          check("hb_unexpected_toggle", cyc, 32'd0);
        end else begin
          le = hb_exp.pop_front();
          check("hb_cycle", cyc, le.c);
          check("hb_value", {31'd0, heartbeat}, {31'd0, le.val[0]});
        end
      end
      if (led_out_n !== prev_led) begin
        if (led_exp.size() == 0) begin
          check("led_unexpected_change", {30'd0, led_out_n}, {30'd0, prev_led});
        end else begin
          le = led_exp.pop_front();
          check("led_cycle", cyc, le.c);
          check("led_out_n", {30'd0, led_out_n}, {30'd0, le.val});
        end
      end
    end
    prev_q   = btn_q;
    prev_led = led_out_n;
    prev_hb  = heartbeat;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_out_n"}, {31'd0, rst_out_n}, 32'd0);
    check({tag, "_btn_q"}, {30'd0, btn_q}, 32'd0);
    check({tag, "_btn_press"}, {30'd0, btn_press}, 32'd0);
    check({tag, "_btn_release"}, {30'd0, btn_release}, 32'd0);
    check({tag, "_heartbeat"}, {31'd0, heartbeat}, 32'd0);
    check({tag, "_led_out_n"}, {30'd0, led_out_n}, 32'd3);
  endtask

  initial begin
    int       r0, r1, e;
    bit [7:0] pat;

    step(3);
    check_reset_outputs("por");

    rst_n = 1'b1;
    r0 = cyc;
    for (int k = 1; k <= 40; k++) push_hb(r0 + 5 * k, logic'(k % 2));
    hb_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_n_edge1", {31'd0, rst_out_n}, 32'd0);
    @(negedge clk);
    check("rst_out_n_edge2", {31'd0, rst_out_n}, 32'd1);
    step(1);

    // Clean press and release on button 0.
    e = cyc;
    btn_in[0] = 1'b1;
    push_btn(e + 6, 2'b01, 2'b00, 2'b01);
    step(12);
    e = cyc;
    btn_in[0] = 1'b0;
    push_btn(e + 6, 2'b00, 2'b01, 2'b00);
    step(10);

    // Bouncy press on button 1: samples 1,1,1,0,1,1,1,1 then held.
    pat = 8'b1110_1111;
    e = cyc;
    push_btn(e + 10, 2'b10, 2'b00, 2'b10);
    for (int j = 0; j < 8; j++) begin
      btn_in[1] = pat[7 - j];
      step(1);
    end
    step(8);
    e = cyc;
    btn_in[1] = 1'b0;
    push_btn(e + 6, 2'b00, 2'b10, 2'b00);
    step(10);

    // Single LED pulse, then a second pulse during the stretch.
    e = cyc;
    push_led(e + 1, 2'b10);
    push_led(e + 5, 2'b11);
    led_in[0] = 1'b1;
    step(1);
    led_in[0] = 1'b0;
    step(8);
    e = cyc;
    push_led(e + 1, 2'b10);
    push_led(e + 7, 2'b11);
    led_in[0] = 1'b1;
    step(1);
    led_in[0] = 1'b0;
    step(1);
    led_in[0] = 1'b1;
    step(1);
    led_in[0] = 1'b0;
    step(10);

    while (cyc < r0 + 202) step(1);
    hb_en = 1'b0;
    check("hb_all_toggles_seen", hb_exp.size(), 32'd0);

    // Reset mid-run with button 0 held and LED 0 stretching.
    e = cyc;
    btn_in[0] = 1'b1;
    push_btn(e + 6, 2'b01, 2'b00, 2'b01);
    step(10);
    e = cyc;
    push_led(e + 1, 2'b10);
    led_in[0] = 1'b1;
    step(1);
    led_in[0] = 1'b0;
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    step(2);
    rst_n = 1'b1;
    r1 = cyc;
    push_btn(r1 + 6, 2'b01, 2'b00, 2'b01);
    @(negedge clk);
    @(negedge clk);
    check("midrun_rst_out_n_edge1", {31'd0, rst_out_n}, 32'd0);
    @(negedge clk);
    check("midrun_rst_out_n_edge2", {31'd0, rst_out_n}, 32'd1);
    step(10);
    e = cyc;
    btn_in[0] = 1'b0;
    push_btn(e + 6, 2'b00, 2'b01, 2'b00);
    step(12);

    check("btn_events_left", btn_exp.size(), 32'd0);
    check("led_events_left", led_exp.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_io_conditioner.md
# board_io_conditioner

Parametrised board-level I/O conditioner placed between FPGA pins and the `tt_um_*` core in board top-levels. It provides:
- a synchronised reset for the core;
- debounced push-button levels with press/release strobes for any number of buttons;
- an exact-period heartbeat toggle;
- per-LED pulse stretching with active-low drive, so single-cycle core events are visible on board LEDs.

It replaces ad-hoc free-running blink counters and raw button wiring in board tops.

## Interface
Parameters:
- `N_BTN`, 3, number of buttons (≥1)
- `N_LED`, 8, number of stretched LED channels (≥1)
- `DEBOUNCE_CYCLES`, 120000, consecutive stable cycles required to accept a button change (≥1)
- `HEARTBEAT_CYCLES`, 12000000, cycles between heartbeat toggles (≥2)
- `STRETCH_CYCLES`, 1200000, extra on-cycles added after the last high input cycle (≥0)

Ports:
- `clk` in 1: single system clock
- `rst_n` in 1: reset, asynchronous, active-low; resets every flop in the block
- `btn_in` in N_BTN: raw button pins, active-high, asynchronous to `clk`
- `led_in` in N_LED: LED requests from the core, active-high, synchronous
- `rst_out_n` out 1: reset for the core; asserts asynchronously, deasserts synchronously
- `btn_q` out N_BTN: debounced button levels
- `btn_press` out N_BTN: 1-cycle strobe on accepted 0→1
- `btn_release` out N_BTN: 1-cycle strobe on accepted 1→0
- `heartbeat` out 1: square wave, period 2×HEARTBEAT_CYCLES
- `led_out_n` out N_LED: stretched LED drive, active-low

## Operation
- Reset values:
  - `rst_out_n`=0, `btn_q`=0, `btn_press`=0, `btn_release`=0
  - `heartbeat`=0
  - `led_out_n`=all 1 (LEDs off)
  - all counters 0
- Reset synchroniser:
  - 2-flop chain fed with 1.
  - `rst_out_n` falls combinationally-asynchronously with `rst_n`.
  - `rst_out_n` rises on the 2nd rising `clk` edge after `rst_n` deasserts.
- Button path, per bit:
  - 2-flop synchroniser produces `s`.
  - Counter `dc`, width $clog2(DEBOUNCE_CYCLES+1).
  - If `s`==`btn_q`: `dc`←0.
  - Else if `dc`==DEBOUNCE_CYCLES-1: `btn_q`←`s`, `dc`←0, and the matching strobe (press or release) is registered high for exactly that one cycle.
  - Else: `dc`←`dc`+1.
  - Any bounce back to `btn_q` restarts the count from 0.
- Heartbeat:
  - Counter `hc` runs 0..HEARTBEAT_CYCLES-1 and wraps to 0.
  - `heartbeat` toggles on the cycle `hc` wraps.
  - The period is exact, with no off-by-one extra cycle.
- LED stretch, per bit:
  - Counter `sc`, width $clog2(STRETCH_CYCLES+1).
  - If `led_in`=1: `sc`←STRETCH_CYCLES and `led_out_n`←0.
  - Else if `sc`>0: `sc`←`sc`-1 and `led_out_n`←0.
  - Else: `led_out_n`←1.
  - A new request while stretching reloads the counter; request time is never accumulated.
  - With STRETCH_CYCLES=0 this reduces to a registered inversion.
- Reset mid-operation:
  - All state clears immediately.
  - A strobe in flight is dropped.
  - A button held through reset is re-accepted as a press after the normal debounce latency.

## Timing
- `rst_out_n` deassert latency: 2 cycles.
- Button latency:
  - From a clean `btn_in` edge to `btn_q` and strobe: 2 (sync) + DEBOUNCE_CYCLES cycles.
  - `btn_press` and `btn_q` rise on the same edge.
- Strobes never overlap on the same bit.
- Minimum spacing between strobes on one bit is DEBOUNCE_CYCLES cycles.
- Bits are independent; simultaneous events on different bits are all reported in the same cycle.
- Heartbeat: first toggle occurs HEARTBEAT_CYCLES cycles after reset release; subsequent toggles every HEARTBEAT_CYCLES cycles.
- LED latency and duration:
  - `led_out_n` goes low 1 cycle after `led_in` is sampled high.
  - A high run of k cycles yields a low run of k+STRETCH_CYCLES cycles.
- All outputs except `rst_out_n` assertion are registered.

## Structure
- Package `board_io_pkg`:
  - `CLK_HZ_ICEBREAKER`=12000000
  - `ms_to_cycles(clk_hz, ms)` function used to derive default parameters
  - `cnt_w(n)` width helper (`$clog2(n+1)`)
- Sub-module `btn_debounce`: one button bit, synchroniser, counter, level and strobes. Instantiated N_BTN times via generate.
- Reset synchroniser, heartbeat and LED stretch stay inline.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HEARTBEAT_CYCLES=5, STRETCH_CYCLES=3, N_BTN=2, N_LED=2.

- **Reset:** assert `rst_n` mid-run.
  - All outputs take their reset values at once; `led_out_n`=2'b11.
  - Release `rst_n`: `rst_out_n` rises on the 2nd edge.
- **Clean press:** `btn_in[0]` 0→1 held.
  - `btn_q[0]` and a 1-cycle `btn_press[0]` appear at cycle 6 after the edge.
  - Release gives a 1-cycle `btn_release[0]` 6 cycles after the falling edge.
- **Bounce:** `btn_in[1]` pattern 1,1,1,0,1,1,1,1.
  - No strobe appears before the final run completes.
  - `btn_press[1]` appears 6 cycles after the last 0→1.
  - `btn_q[0]` stays 0.
- **Heartbeat:** after reset release, `heartbeat` toggles at cycles 5, 10, 15.
  - High and low phases are exactly 5 cycles each over 20 periods.
- **LED stretch:**
  - A 1-cycle `led_in[0]` pulse gives `led_out_n[0]`=0 for exactly 4 cycles, starting 1 cycle later.
  - A second pulse during the stretch extends it to 4 cycles after the second pulse.
  - `led_out_n[1]` remains 1 throughout.
